// File: rtl/game_physics.sv
// Pong game-state engine: once per frame_tick it moves the pads, advances the ball and resolves
// wall bounces, pad hits, misses and scoring. All coordinates are pixel centres.
module game_physics #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PAD_DISTANCE  = 16,
  parameter int PAD_WIDTH     = 8,
  parameter int PAD_HEIGHT    = 64,
  parameter int BALL_R        = 4,
  parameter int PAD_SPEED     = 4,
  parameter int BALL_SPEED    = 2,
  parameter int SERVE_FRAMES  = 60,
  parameter int MAX_SCORE     = 9
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_left_up,
  input  logic        btn_left_down,
  input  logic        btn_right_up,
  input  logic        btn_right_down,
  input  logic        btn_start,
  output logic [11:0] pad_left,
  output logic [11:0] pad_right,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        game_over
);

  // state | meaning
  // SERVE | ball parked at centre, counting serve frames
  // PLAY  | ball moving; walls, pads and misses resolved each frame
  // OVER  | a player reached MAX_SCORE; waiting for btn_start

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  localparam int SW = $clog2(SERVE_FRAMES);
  localparam logic [11:0] X_CTR = 12'(SCREEN_WIDTH / 2);
  localparam logic [11:0] Y_CTR = 12'(SCREEN_HEIGHT / 2);
  localparam logic [3:0]  MAX   = 4'(MAX_SCORE);
  localparam logic signed [12:0] PAD_MIN = 13'(PAD_HEIGHT / 2 + 1);
  localparam logic signed [12:0] PAD_MAX = 13'(SCREEN_HEIGHT - 2 - PAD_HEIGHT / 2);
  localparam logic signed [12:0] B_MIN   = 13'(BALL_R + 1);
  localparam logic signed [12:0] BX_MAX  = 13'(SCREEN_WIDTH - 2 - BALL_R);
  localparam logic signed [12:0] BY_MAX  = 13'(SCREEN_HEIGHT - 2 - BALL_R);
  localparam logic signed [12:0] XL      = 13'(PAD_DISTANCE + PAD_WIDTH);
  localparam logic signed [12:0] XR      = 13'(SCREEN_WIDTH - 1 - PAD_DISTANCE - PAD_WIDTH);
  localparam logic signed [12:0] R       = 13'(BALL_R);
  localparam logic signed [12:0] SPD     = 13'(BALL_SPEED);
  localparam logic signed [12:0] PSPD    = 13'(PAD_SPEED);
  localparam logic signed [12:0] REACH   = 13'(PAD_HEIGHT / 2 + BALL_R);

  state_t          state_q, state_d;
  logic [11:0]     pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [11:0]     bx_q, bx_d, by_q, by_d;
  logic            dx_q, dx_d, dy_q, dy_d;   // 1 = right / down
  logic [3:0]      sl_q, sl_d, sr_q, sr_d;
  logic [SW-1:0]   serve_q, serve_d;

  logic signed [12:0] nx, ny, nx_w, ny_w, dist_l, dist_r;
  logic               dx_w, dy_w, hit_l, hit_r, miss_l, miss_r;

  function automatic logic [11:0] pad_next(input logic [11:0] p, input logic up, input logic dn);
    logic signed [12:0] t;
    t = $signed({1'b0, p});
    if (up && !dn) begin
      t = t - PSPD;
      if (t < PAD_MIN) t = PAD_MIN;
    end else if (dn && !up) begin
      t = t + PSPD;
      if (t > PAD_MAX) t = PAD_MAX;
    end
    return t[11:0];
  endfunction

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q <= SERVE;
      pad_l_q <= Y_CTR;
      pad_r_q <= Y_CTR;
      bx_q    <= X_CTR;
      by_q    <= Y_CTR;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sl_q    <= '0;
      sr_q    <= '0;
      serve_q <= '0;
    end else if (frame_tick) begin
      state_q <= state_d;
      pad_l_q <= pad_l_d;
      pad_r_q <= pad_r_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      serve_q <= serve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pad_l_d = pad_next(pad_l_q, btn_left_up, btn_left_down);
    pad_r_d = pad_next(pad_r_q, btn_right_up, btn_right_down);
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    serve_d = serve_q;

    nx   = $signed({1'b0, bx_q}) + (dx_q ? SPD : -SPD);
    ny   = $signed({1'b0, by_q}) + (dy_q ? SPD : -SPD);
    ny_w = ny;
    dy_w = dy_q;
    if (ny < B_MIN) begin
      ny_w = B_MIN;
      dy_w = 1'b1;
    end else if (ny > BY_MAX) begin
      ny_w = BY_MAX;
      dy_w = 1'b0;
    end

    // Pad tests use the wall-corrected y and the pad positions from before this frame.
    dist_l = ny_w - $signed({1'b0, pad_l_q});
    dist_l = dist_l[12] ? -dist_l : dist_l;
    dist_r = ny_w - $signed({1'b0, pad_r_q});
    dist_r = dist_r[12] ? -dist_r : dist_r;
    hit_l  = !dx_q && (nx - R <= XL) && ($signed({1'b0, bx_q}) - R > XL - SPD) && (dist_l < REACH);
    hit_r  = dx_q && (nx + R >= XR) && ($signed({1'b0, bx_q}) + R < XR + SPD) && (dist_r < REACH);

    nx_w = nx;
    dx_w = dx_q;
    if (hit_l) begin
      nx_w = XL + R;
      dx_w = 1'b1;
    end else if (hit_r) begin
      nx_w = XR - R;
      dx_w = 1'b0;
    end
    miss_l = !dx_q && !hit_l && (nx < B_MIN);
    miss_r = dx_q && !hit_r && (nx > BX_MAX);

    case (state_q)
      SERVE: begin
        bx_d = X_CTR;
        by_d = Y_CTR;
        if (serve_q == SW'(SERVE_FRAMES - 1)) begin
          state_d = PLAY;
          serve_d = '0;
        end else begin
          serve_d = serve_q + SW'(1);
        end
      end
      PLAY: begin
        if (miss_l || miss_r) begin
          // Serve goes toward the player who conceded, so dx keeps its sign.
          bx_d    = X_CTR;
          by_d    = Y_CTR;
          dy_d    = dy_w;
          serve_d = '0;
          if (miss_l) sr_d = sr_q + 4'd1;
          else        sl_d = sl_q + 4'd1;
          state_d = (sl_d == MAX || sr_d == MAX) ? OVER : SERVE;
        end else begin
          bx_d = nx_w[11:0];
          by_d = ny_w[11:0];
          dx_d = dx_w;
          dy_d = dy_w;
        end
      end
      OVER: begin
        bx_d = X_CTR;
        by_d = Y_CTR;
        if (btn_start) begin
          sl_d    = '0;
          sr_d    = '0;
          serve_d = '0;
          state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_comb begin
    pad_left    = pad_l_q;
    pad_right   = pad_r_q;
    ball_x      = bx_q;
    ball_y      = by_q;
    score_left  = sl_q;
    score_right = sr_q;
    game_over   = (state_q == OVER);
  end

endmodule

// File: tb/tb_game_physics.sv
// Bench for game_physics: an integer Pong model checked against the DUT every cycle, plus
// hand-computed literal positions along two scripted serves that pin the model.
module tb_game_physics;

  logic        clk_vga = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_left_up = 1'b0, btn_left_down = 1'b0;
  logic        btn_right_up = 1'b0, btn_right_down = 1'b0;
  logic        btn_start = 1'b0;
  logic [11:0] pad_left, pad_right, ball_x, ball_y;
  logic [3:0]  score_left, score_right;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state: mode 0 = serve, 1 = play, 2 = over
  int m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_cnt, m_mode;

  game_physics dut (
    .clk_vga(clk_vga), .rst(rst), .frame_tick(frame_tick),
    .btn_left_up(btn_left_up), .btn_left_down(btn_left_down),
    .btn_right_up(btn_right_up), .btn_right_down(btn_right_down),
    .btn_start(btn_start),
    .pad_left(pad_left), .pad_right(pad_right), .ball_x(ball_x), .ball_y(ball_y),
    .score_left(score_left), .score_right(score_right), .game_over(game_over)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic int pad_move(input int p, input bit up, input bit dn);
    if (up && !dn) return (p - 4 < 33) ? 33 : p - 4;
    if (dn && !up) return (p + 4 > 446) ? 446 : p + 4;
    return p;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_play();
    int nx, ny;
    bit hit;
    nx = m_bx + 2 * m_dx;
    ny = m_by + 2 * m_dy;
    if (ny < 5) begin ny = 5; m_dy = 1; end
    else if (ny > 474) begin ny = 474; m_dy = -1; end
    hit = 0;
    if (m_dx < 0 && nx - 4 <= 24 && m_bx - 4 > 22 && iabs(ny - m_pl) < 36) begin
      nx = 28; m_dx = 1; hit = 1;
    end else if (m_dx > 0 && nx + 4 >= 615 && m_bx + 4 < 617 && iabs(ny - m_pr) < 36) begin
      nx = 611; m_dx = -1; hit = 1;
    end
    if (!hit && m_dx < 0 && nx < 5) begin
      m_sr++; m_bx = 320; m_by = 240; m_cnt = 0;
      m_mode = (m_sr == 9) ? 2 : 0;
    end else if (!hit && m_dx > 0 && nx > 634) begin
      m_sl++; m_bx = 320; m_by = 240; m_cnt = 0;
      m_mode = (m_sl == 9) ? 2 : 0;
    end else begin
      m_bx = nx; m_by = ny;
    end
  endtask

  always @(posedge clk_vga) begin
    if (rst) begin
      m_pl = 240; m_pr = 240; m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0; m_cnt = 0; m_mode = 0;
    end else if (frame_tick) begin
      if (m_mode == 0) begin
        if (m_cnt == 59) begin m_mode = 1; m_cnt = 0; end
        else m_cnt++;
      end else if (m_mode == 1) begin
        m_play();
      end else if (btn_start) begin
        m_sl = 0; m_sr = 0; m_cnt = 0; m_mode = 0;
      end
      m_pl = pad_move(m_pl, btn_left_up, btn_left_down);
      m_pr = pad_move(m_pr, btn_right_up, btn_right_down);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk_vga);
      if (chk_en) begin
        check("model pad_left", int'(pad_left), m_pl);
        check("model pad_right", int'(pad_right), m_pr);
        check("model ball_x", int'(ball_x), m_bx);
        check("model ball_y", int'(ball_y), m_by);
        check("model score_left", int'(score_left), m_sl);
        check("model score_right", int'(score_right), m_sr);
        check("model game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
      end
    end
  endtask

  // called just after a posedge; returns just after a posedge, with one tick-free cycle per frame
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk_vga); #1;
      frame_tick = 1'b0;
      @(posedge clk_vga); #1;
    end
  endtask

  task automatic check_ball(input string nm, input int x, input int y);
    check({nm, " x"}, int'(ball_x), x);
    check({nm, " y"}, int'(ball_y), y);
  endtask

  initial begin
    int guard;
    fork cmp_loop(); join_none
    @(posedge clk_vga); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    check("reset pad_left", int'(pad_left), 240);
    check("reset pad_right", int'(pad_right), 240);
    check_ball("reset ball", 320, 240);
    check("reset scores", int'(score_left) + int'(score_right), 0);
    check("reset game_over", int'(game_over), 0);
    btn_left_up = 1'b1;
    repeat (6) @(posedge clk_vga);
    #1;
    check("no tick pad_left held", int'(pad_left), 240);
    btn_left_up = 1'b0;

    // first serve: dx=+, dy=+
    tick(59);
    check_ball("serve 59 ticks", 320, 240);
    tick(1);
    check_ball("serve 60th tick", 320, 240);
    tick(1);
    check_ball("first move", 322, 242);
    btn_left_up = 1'b1;
    tick(100);
    check("pad clamp top", int'(pad_left), 33);
    btn_left_down = 1'b1;
    tick(5);
    check("pad both held", int'(pad_left), 33);
    btn_left_up = 1'b0; btn_left_down = 1'b0;
    tick(12);
    check_ball("bottom wall clamp", 556, 474);
    tick(1);
    check_ball("after bottom bounce", 558, 472);
    tick(38);
    check_ball("before right miss", 634, 396);
    tick(1);
    check("right miss score_left", int'(score_left), 1);
    check_ball("recentred after miss", 320, 240);

    // second serve: dx=+, dy=-, right pad raised to meet the ball
    btn_right_up = 1'b1;
    tick(60);
    check_ball("second serve held", 320, 240);
    tick(118);
    check_ball("top wall clamp", 556, 5);
    tick(1);
    check_ball("after top bounce", 558, 7);
    tick(26);
    check_ball("before right pad", 610, 59);
    check("pad_right clamp", int'(pad_right), 33);
    tick(1);
    check_ball("right pad hit", 611, 61);
    tick(1);
    check_ball("moving left after hit", 609, 63);
    btn_right_up = 1'b0;

    guard = 0;
    while (m_mode != 2 && guard < 20000) begin
      btn_left_up = 1'($urandom_range(0, 1));
      btn_left_down = 1'($urandom_range(0, 1));
      btn_right_up = 1'($urandom_range(0, 1));
      btn_right_down = 1'($urandom_range(0, 1));
      tick(1);
      guard++;
    end
    btn_left_up = 1'b0; btn_left_down = 1'b0; btn_right_up = 1'b0; btn_right_down = 1'b0;
    check("game_over reached", int'(game_over), 1);
    check("winner at max", (score_left == 4'd9 || score_right == 4'd9) ? 1 : 0, 1);
    check_ball("over ball centre", 320, 240);
    tick(3);
    check("over still set", int'(game_over), 1);
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    check("restart scores", int'(score_left) + int'(score_right), 0);
    check("restart game_over", int'(game_over), 0);

    for (int i = 0; i < 100; i++) begin
      btn_left_up = 1'($urandom_range(0, 1));
      btn_right_down = 1'($urandom_range(0, 1));
      tick(1);
    end
    rst = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk_vga); #1;
    rst = 1'b0;
    frame_tick = 1'b0;
    btn_left_up = 1'b0; btn_right_down = 1'b0;
    check("mid-play reset pad_left", int'(pad_left), 240);
    check("mid-play reset pad_right", int'(pad_right), 240);
    check_ball("mid-play reset ball", 320, 240);
    check("mid-play reset scores", int'(score_left) + int'(score_right), 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
